// File: rtl/pipe_pkg.sv
// pipe_pkg: definitions shared by the pipeline stage registers.
//   NOP_INST     : bubble instruction encoding (all ones) for 32-bit instructions.
//   fd_payload_t : fetch/decode payload {inst, pc, guess} at the default 32/32 widths.
//   occ_count()  : entry count from the head-valid and second-entry-valid flags.
package pipe_pkg;

  localparam int FD_INST_W = 32;
  localparam int FD_PC_W   = 32;

  localparam logic [FD_INST_W-1:0] NOP_INST = '1;

  typedef struct packed {
    logic [FD_INST_W-1:0] inst;
    logic [FD_PC_W-1:0]   pc;
    logic                 guess;
  } fd_payload_t;

  // The second entry can only be occupied while the head is, so the
  // count is 2 when full, 1 when only the head is valid, else 0.
  function automatic logic [1:0] occ_count(input logic head_valid, input logic full);
    return {full, head_valid & ~full};
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic two-entry valid/ready skid buffer.
//   clk       : clock; state updates on the falling edge
//   rst       : synchronous active-low reset
//   flush     : discard both entries
//   in_valid  / in_ready / in_data   : upstream handshake and payload
//   out_valid / out_ready / out_data : downstream handshake and head payload
//   full      : second (skid) entry occupied
// in_ready is a plain register (!skid valid), so it has no combinational
// dependency on out_ready.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         full
);

  logic         main_valid_reg;
  logic         skid_valid_reg;
  logic [W-1:0] main_data_reg;
  logic [W-1:0] skid_data_reg;

  always_ff @(negedge clk) begin
    if (!rst) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (skid_valid_reg) begin
      // Full: nothing is accepted; a release promotes skid into main.
      if (out_ready) begin
        main_data_reg  <= skid_data_reg;
        skid_valid_reg <= 1'b0;
      end
    end else if (in_valid) begin
      if (!main_valid_reg || out_ready) begin
        // Main empty or leaving this edge: new data lands in main.
        main_valid_reg <= 1'b1;
        main_data_reg  <= in_data;
      end else begin
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= in_data;
      end
    end else if (out_ready) begin
      main_valid_reg <= 1'b0;
    end
  end

  assign in_ready  = !skid_valid_reg;
  assign out_valid = main_valid_reg;
  assign out_data  = main_data_reg;
  assign full      = skid_valid_reg;

endmodule

// File: rtl/fd_pipe_reg.sv
// fd_pipe_reg: fetch/decode pipeline register with valid/ready handshake.
//   clk, rst (sync active-low), flush : control; state updates on the falling edge
//   in_valid/in_ready, in_inst/in_pc/in_guess      : fetch side
//   out_valid/out_ready, out_inst/out_pc/out_guess : decode side (bubble values when empty)
//   occupancy : number of held entries
// SKID=1 uses a two-entry skid buffer (registered in_ready); SKID=0 uses a
// single entry whose in_ready follows out_ready combinationally.
module fd_pipe_reg
  import pipe_pkg::*;
#(
  parameter int              INST_W      = 32,
  parameter int              PC_W        = 32,
  parameter logic [INST_W-1:0] BUBBLE_INST = {INST_W{1'b1}},
  parameter int              SKID        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_guess,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_guess,
  output logic [1:0]        occupancy
);

  localparam int PW = INST_W + PC_W + 1;

  logic [PW-1:0] in_data;
  logic [PW-1:0] head_data;
  logic          head_valid;
  logic          head_full;

  assign in_data = {in_inst, in_pc, in_guess};

  if (SKID != 0) begin : g_skid
    pipe_skid_buf #(.W(PW)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (head_valid),
      .out_ready (out_ready),
      .out_data  (head_data),
      .full      (head_full)
    );
  end else begin : g_single
    logic          main_valid_reg;
    logic [PW-1:0] main_data_reg;

    always_ff @(negedge clk) begin
      if (!rst) begin
        main_valid_reg <= 1'b0;
      end else if (flush) begin
        main_valid_reg <= 1'b0;
      end else if (in_valid && in_ready) begin
        main_valid_reg <= 1'b1;
        main_data_reg  <= in_data;
      end else if (out_ready) begin
        main_valid_reg <= 1'b0;
      end
    end

    // Accept when empty or when the held entry leaves at the same edge.
    assign in_ready   = !main_valid_reg || out_ready;
    assign head_valid = main_valid_reg;
    assign head_data  = main_data_reg;
    assign head_full  = 1'b0;
  end

  // Bubble forcing: fields are masked from registered state only.
  assign out_valid = head_valid;
  assign out_inst  = head_valid ? head_data[PW-1 -: INST_W] : BUBBLE_INST;
  assign out_pc    = head_valid ? head_data[PC_W:1] : '0;
  assign out_guess = head_valid & head_data[0];
  assign occupancy = occ_count(head_valid, head_full);

endmodule

// File: tb/tb_fd_pipe_reg.sv
// tb_fd_pipe_reg: drives one stimulus stream into a SKID=1 and a SKID=0
// instance. Per instance, an issue process pushes expected payloads into a
// FIFO when the reference model says the offer is taken; a monitor process
// compares the outputs against the FIFO head and pops on release.
module tb_fd_pipe_reg;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        guess;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        in_guess = 1'b0;
  logic        out_ready = 1'b0;
  bit          started = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // State is valid once a reset edge has been seen.
  always @(negedge clk) if (!rst) started <= 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam bit SK = (gi == 0);
    logic        rdy, ov, og;
    logic [31:0] oi, op;
    logic [1:0]  occ;
    exp_t        q[$];
    bit          acc;

    fd_pipe_reg #(.SKID(SK ? 1 : 0)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (rdy),
      .in_inst   (in_inst),
      .in_pc     (in_pc),
      .in_guess  (in_guess),
      .out_valid (ov),
      .out_ready (out_ready),
      .out_inst  (oi),
      .out_pc    (op),
      .out_guess (og),
      .occupancy (occ)
    );

    // Issue side: decide on the pre-edge entry count, push after the monitor.
    initial forever begin
      @(posedge clk);
      #2;
      acc = rst && !flush && in_valid &&
            (SK ? (q.size() < 2) : (q.size() == 0 || out_ready));
      #2;
      if (acc) q.push_back('{in_inst, in_pc, in_guess});
    end

    // Monitor: compare held state, then apply release / flush / reset.
    initial forever begin
      string tag;
      @(posedge clk);
      #3;
      if (started) begin
        tag = SK ? "skid1" : "skid0";
        check({tag, " in_ready"}, 32'(rdy),
              32'(SK ? (q.size() < 2) : (q.size() == 0 || out_ready)));
        check({tag, " out_valid"}, 32'(ov), 32'(q.size() > 0));
        check({tag, " occupancy"}, 32'(occ), 32'(q.size()));
        if (q.size() > 0) begin
          check({tag, " out_inst"}, oi, q[0].inst);
          check({tag, " out_pc"}, op, q[0].pc);
          check({tag, " out_guess"}, 32'(og), 32'(q[0].guess));
        end else begin
          check({tag, " bubble_inst"}, oi, 32'hFFFF_FFFF);
          check({tag, " bubble_pc"}, op, 32'h0);
          check({tag, " bubble_guess"}, 32'(og), 32'h0);
        end
        if (!rst) q.delete();
        else begin
          if (out_ready && q.size() > 0) void'(q.pop_front());
          if (flush) q.delete();
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit fl, input bit v, input logic [31:0] i,
                     input logic [31:0] p, input bit g, input bit ordy);
    @(posedge clk);
    #1;
    rst = r; flush = fl; in_valid = v; in_inst = i; in_pc = p; in_guess = g; out_ready = ordy;
  endtask

  initial begin
    // Reset with an offer present.
    cyc(0, 0, 1, 32'h1111_1111, 32'h100, 1, 1);
    cyc(0, 0, 1, 32'h1111_1111, 32'h100, 1, 1);
    // Streaming.
    cyc(1, 0, 1, 32'h0000_0013, 32'h0, 0, 1);
    cyc(1, 0, 1, 32'h0010_0093, 32'h4, 0, 1);
    cyc(1, 0, 1, 32'h0020_0113, 32'h8, 0, 1);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
    // Backpressure: third offer must be ignored.
    cyc(1, 0, 1, 32'hA000_0010, 32'h10, 0, 0);
    cyc(1, 0, 1, 32'hA000_0014, 32'h14, 1, 0);
    cyc(1, 0, 1, 32'hA000_0018, 32'h18, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
    // Flush with the skid full and an offer present.
    cyc(1, 0, 1, 32'hB000_0030, 32'h30, 1, 0);
    cyc(1, 0, 1, 32'hB000_0034, 32'h34, 0, 0);
    cyc(1, 1, 1, 32'hB000_0040, 32'h40, 1, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
    // Guess held for several cycles, then replaced on release.
    cyc(1, 0, 1, 32'hC000_0020, 32'h20, 1, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 0);
    cyc(1, 0, 1, 32'hC000_0028, 32'h28, 0, 1);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
    cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7,
          $urandom, $urandom, 1'($urandom), $urandom_range(0, 9) < 6);
    end
    // Drain.
    for (int n = 0; n < 4; n++) cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
    @(posedge clk);
    #6;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fd_pipe_reg.md
Name: fd_pipe_reg

Overview:
- Next-generation fetch/decode pipeline register with a valid/ready handshake, replacing the stall-driven register.
- Payload is instruction, PC and branch-prediction guess bit; payload widths are parametrised.
- An optional 2-entry skid buffer cuts the combinational ready path from decode back to fetch.
- Flush inserts bubbles. Sits between the fetch stage and the decoder.

Parameters:
- INST_W, 32, instruction width.
- PC_W, 32, program-counter width.
- BUBBLE_INST, {INST_W{1'b1}}, instruction value presented when no valid entry (NOP/bubble encoding).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  pipeline clock; all state updates on the falling edge, matching the pipeline register convention.
- rst  in  1  synchronous active-low reset, sampled on the clk falling edge.
- flush  in  1  discard all held entries (branch mispredict / redirect).
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  register can accept this cycle.
- in_inst  in  INST_W  fetched instruction.
- in_pc  in  PC_W  PC of in_inst.
- in_guess  in  1  branch predictor taken-guess for in_inst.
- out_valid  out  1  decode-side entry valid.
- out_ready  in  1  decoder consumes this cycle (inverse of the legacy stall).
- out_inst  out  INST_W  head instruction; BUBBLE_INST when out_valid=0.
- out_pc  out  PC_W  head PC; 0 when out_valid=0.
- out_guess  out  1  head guess; 0 when out_valid=0.
- occupancy  out  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Clocking and reset:
  - Single clock domain; the reset is synchronous, active-low, named rst.
  - On rst=0 at a clk edge: both entries empty, out_valid=0, out_inst=BUBBLE_INST, out_pc=0, out_guess=0, occupancy=0, in_ready=1 (SKID=1).
- Transfers:
  - Accept occurs when in_valid && in_ready. Release occurs when out_valid && out_ready.
  - Latency: an accepted instruction appears on out_* after the next active edge (1 cycle), when the pipe is empty.
  - Payload visible on out_* is always the oldest entry; order is strictly FIFO.
  - out_* is driven from registers only; there is no combinational in-to-out path.
- SKID=1:
  - Entries are main (head) and skid.
  - in_ready = !skid_valid, registered.
  - Accept with main empty, or main releasing: data goes to main.
  - Accept while main is held (out_ready=0): data goes to skid.
  - Release with skid valid: skid moves to main; skid empties.
  - Simultaneous accept and release with skid empty: the new data replaces main, and occupancy is unchanged.
  - in_ready cannot be 1 while occupancy=2.
- SKID=0:
  - Single main entry. in_ready = !out_valid || out_ready, combinational from out_ready.
- Flush:
  - Priority: rst > flush > accept/release.
  - flush=1 at an edge: all entries cleared, outputs go to bubble values, occupancy=0.
  - An instruction offered the same cycle is dropped even if in_ready=1.
  - A release the same cycle still counts (decoder saw the head).
  - in_ready=1 on the following cycle.
- Holding: an entry that is not released holds its payload bit-exact indefinitely.
- in_* sampled while in_ready=0 are ignored; no state change.
- out_ready asserted with out_valid=0 is harmless.
- Back-to-back: with out_ready held 1, sustain one accept per cycle (full throughput) in both modes.

Decomposition:
- Shared package pipe_pkg holds the bubble encoding constant (NOP_INST = all ones) and a packed fd_payload_t {inst, pc, guess}, reused by later stage registers.
- One natural sub-module, pipe_skid_buf: a generic 2-entry valid/ready skid buffer on a packed payload of parametrised width.
  - fd_pipe_reg instantiates it when SKID=1, or a single-entry register otherwise.
  - fd_pipe_reg adds bubble forcing and occupancy.

Test Plan:
- Reset: rst=0 for 2 cycles with in_valid=1 -> out_valid=0, out_inst=FFFFFFFF, out_pc=0, occupancy=0; after release, in_ready=1.
- Streaming: out_ready=1, push inst 00000013/00100093/00200113 at pc 0/4/8 on consecutive cycles -> same sequence on out_* one cycle later, no gaps, occupancy stays 1.
- Backpressure (SKID=1): out_ready=0, push pc 0x10 then 0x14 -> occupancy=2, in_ready=0, third push (0x18) ignored; raise out_ready -> 0x10, then 0x14 emitted, then in_ready=1.
- Flush with full skid: occupancy=2, flush=1 with in_valid=1 (pc 0x40) -> next cycle out_valid=0, out_inst=FFFFFFFF, out_guess=0, occupancy=0; 0x40 never appears.
- Guess propagation: push pc 0x20 with in_guess=1 while out_ready=0 for 3 cycles -> out_guess=1, out_pc=0x20 stable for all held cycles.
- SKID=0 variant: out_ready=0 with one entry held -> in_ready=0 combinationally; out_ready=1 same cycle -> in_ready=1 and simultaneous replace.
